word_assembler: RTL and testbench
=================================

# word_assembler

Packs an incoming byte stream of text into fixed 256-bit, zero-padded words, one word per token. It sits directly upstream of the MurmurHash3/Bloom-filter stage and hands it one complete word at a time. Letters are folded to lowercase, so the hash stage sees case-insensitive tokens. Every non-letter byte acts as a delimiter.

## Interface
- MAX_BYTES, 32: maximum characters per word; word width is 8*MAX_BYTES.
- clock  in  1  single clock; all logic samples on the rising edge.
- reset  in  1  synchronous, active-high; clears all state on the next rising edge.
- byte_valid  in  1  byte_in is valid this cycle.
- byte_in  in  8  ASCII character.
- byte_last  in  1  qualifies byte_in as the final byte of the stream.
- byte_ready  out  1  block can accept a byte this cycle.
- word  out  8*MAX_BYTES, indexed [8*MAX_BYTES:1]  packed word; character k (0-based) occupies bits [8k+8:8k+1]; unused bytes are 0.
- word_len  out  6  number of characters stored (1..32).
- word_truncated  out  1  the token exceeded MAX_BYTES; extra characters were dropped.
- word_valid  out  1  word, word_len and word_truncated are valid and held.
- word_taken  in  1  consumer pulse; accepted only while word_valid=1.

## Operation
- FSM states:
  - COLLECT (reset state): byte_ready=1, word_valid=0.
  - EMIT: byte_ready=0, word_valid=1.
- A byte is accepted on byte_valid & byte_ready.
- Letter (0x41–0x5A, 0x61–0x7A):
  - Folded to lowercase (0x41–0x5A are OR'd with 0x20).
  - If count < MAX_BYTES: written at byte position count, and count increments.
  - Otherwise: dropped, and the sticky trunc flag is set.
- Non-letter (delimiter):
  - If count > 0: transition to EMIT. The delimiter is consumed and is not stored.
  - If count = 0: ignored. Empty tokens are never emitted.
- byte_last=1 with an accepted byte:
  - The byte is processed as above.
  - Then, if count > 0 after processing, transition to EMIT. This includes a letter as the final byte.
- EMIT → COLLECT on word_taken=1.
  - Clears the word buffer to 0, count to 0 and trunc to 0.
- word_taken while in COLLECT is ignored.
- word_len equals count, saturating at 32. word_truncated equals trunc.
- reset at any time, including mid-token or in EMIT:
  - State COLLECT, buffer 0, count 0, trunc 0.
  - Outputs: word_valid=0, word=0, word_len=0, word_truncated=0, byte_ready=1 from the cycle after reset is sampled.

## Timing
- Reset values: byte_ready=1, word_valid=0, word=0, word_len=0, word_truncated=0.
- Each accepted letter is visible in word on the following cycle. word is not qualified until word_valid=1.
- Latency:
  - Delimiter accepted at edge N → word_valid=1 after edge N, byte_ready=0 in the same cycle.
  - word_taken sampled at edge M → word_valid=0 and byte_ready=1 after edge M.
- Maximum throughput is one byte per cycle while in COLLECT. Each emitted word costs at least one stall cycle.
- All outputs are registered except byte_ready, which is decoded directly from the state.
- Outputs are stable throughout EMIT regardless of byte_valid and byte_in.

## Structure
- Shared package censor_pkg holds:
  - MAX_WORD_BYTES=32, WORD_BITS=256
  - state enum {COLLECT, EMIT}
  - ASCII range constants for the letter ranges
- The hash/Bloom stage imports the same WORD_BITS.
- One combinational sub-module, char_normalizer:
  - Input: byte_in.
  - Outputs: is_letter and lower[7:0].
  - Unit-tested separately.

## Test plan
- Bytes 0x48 0x69 0x2C 0x20 0x63 0x61 0x74 (last on 0x74), word_taken pulsed one cycle after each word_valid:
  - Word 1: word[16:1]=0x6968, rest 0, word_len=2.
  - Word 2: word[24:1]=0x746163, word_len=3.
  - The 0x2C 0x20 pair yields no empty word.
- 40 letters 0x61 then 0x20:
  - word = all bytes 0x61.
  - word_len=32, word_truncated=1.
  - The next token has word_truncated=0.
- Stall check: hold word_valid 10 cycles without word_taken while byte_valid=1:
  - byte_ready=0 throughout, word unchanged.
  - Bytes are not consumed until one cycle after word_taken.
- Assert reset after 0x61 0x62 mid-token, then send 0x63 0x20:
  - Emitted word[8:1]=0x63, word_len=1.
  - No trace of "ab".
- Mixed case and ranges: 0x5A 0x40 0x5B 0x7A 0x7B:
  - Two words, word[8:1]=0x7A each.
  - 0x40, 0x5B and 0x7B are treated as delimiters.
- word_taken pulsed in COLLECT with no pending word: no state change and no spurious word_valid.

Source files
------------

// File: rtl/censor_pkg.sv
// Shared constants and types for the text-censor pipeline: word geometry,
// FSM states and the ASCII letter ranges.
package censor_pkg;
  localparam int MAX_WORD_BYTES = 32;
  localparam int WORD_BITS      = 8 * MAX_WORD_BYTES;
  localparam int LEN_BITS       = 6;

  localparam logic [LEN_BITS-1:0] MAX_LEN = LEN_BITS'(MAX_WORD_BYTES);

  localparam logic [7:0] ASCII_UPPER_A = 8'h41;
  localparam logic [7:0] ASCII_UPPER_Z = 8'h5A;
  localparam logic [7:0] ASCII_LOWER_A = 8'h61;
  localparam logic [7:0] ASCII_LOWER_Z = 8'h7A;
  localparam logic [7:0] ASCII_CASE_BIT = 8'h20;

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } state_e;
endpackage

// File: rtl/word_assembler_if.sv
// Byte-stream input and packed-word output handshake of the word assembler.
interface word_assembler_if;
  import censor_pkg::*;

  logic                  byte_valid;
  logic [7:0]            byte_in;
  logic                  byte_last;
  logic                  byte_ready;
  logic [WORD_BITS:1]    word;
  logic [LEN_BITS-1:0]   word_len;
  logic                  word_truncated;
  logic                  word_valid;
  logic                  word_taken;

  modport master (
    output byte_valid, byte_in, byte_last, word_taken,
    input  byte_ready, word, word_len, word_truncated, word_valid
  );

  modport slave (
    input  byte_valid, byte_in, byte_last, word_taken,
    output byte_ready, word, word_len, word_truncated, word_valid
  );
endinterface

// File: rtl/char_normalizer.sv
// Classifies a byte as an ASCII letter and folds uppercase to lowercase.
module char_normalizer
  import censor_pkg::*;
(
  input  logic [7:0] byte_i,
  output logic       is_letter_o,
  output logic [7:0] lower_o
);
  logic is_upper;
  logic is_lower;

  assign is_upper    = (byte_i >= ASCII_UPPER_A) && (byte_i <= ASCII_UPPER_Z);
  assign is_lower    = (byte_i >= ASCII_LOWER_A) && (byte_i <= ASCII_LOWER_Z);
  assign is_letter_o = is_upper || is_lower;
  assign lower_o     = is_upper ? (byte_i | ASCII_CASE_BIT) : byte_i;
endmodule

// File: rtl/word_assembler.sv
// Packs letters of a byte stream into zero-padded lowercase words, one per
// token, and holds each word until the downstream hash stage takes it.
module word_assembler
  import censor_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  word_assembler_if.slave   bus
);
  state_e              state_q;
  logic [WORD_BITS:1]  word_q;
  logic [LEN_BITS-1:0] cnt_q;
  logic                trunc_q;
  logic                valid_q;

  logic                is_letter;
  logic [7:0]          lower;

  char_normalizer u_norm (
    .byte_i      (bus.byte_in),
    .is_letter_o (is_letter),
    .lower_o     (lower)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= COLLECT;
      word_q  <= '0;
      cnt_q   <= '0;
      trunc_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (bus.byte_valid) begin
            if (is_letter) begin
              if (cnt_q < MAX_LEN) begin
                for (int k = 0; k < MAX_WORD_BYTES; k++) begin
                  if (cnt_q == LEN_BITS'(k)) word_q[8*k+1 +: 8] <= lower;
                end
                cnt_q <= cnt_q + 1'b1;
              end else begin
                trunc_q <= 1'b1;
              end
              // a letter always leaves count > 0, so a final letter closes the token
              if (bus.byte_last) begin
                state_q <= EMIT;
                valid_q <= 1'b1;
              end
            end else if (cnt_q != '0) begin
              state_q <= EMIT;
              valid_q <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (bus.word_taken) begin
            state_q <= COLLECT;
            valid_q <= 1'b0;
            word_q  <= '0;
            cnt_q   <= '0;
            trunc_q <= 1'b0;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign bus.byte_ready     = (state_q == COLLECT);
  assign bus.word_valid     = valid_q;
  assign bus.word           = word_q;
  assign bus.word_len       = cnt_q;
  assign bus.word_truncated = trunc_q;
endmodule

// File: tb/tb_word_assembler.sv
// Self-checking bench for word_assembler: table-driven byte vectors feed an
// expected-word queue that a monitor pops when each word is presented.
module tb_word_assembler;
  import censor_pkg::*;

  typedef struct {
    logic [7:0]          b;
    logic                last;
    logic                emit;
    logic [WORD_BITS:1]  exp_word;
    logic [LEN_BITS-1:0] exp_len;
    logic                exp_trunc;
  } vec_t;

  typedef struct {
    logic [WORD_BITS:1]  word;
    logic [LEN_BITS-1:0] len;
    logic                trunc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  word_assembler_if bus();

  word_assembler dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];
  int   take_delay = 0;

  task automatic check(input string name, input logic [WORD_BITS:1] act,
                       input logic [WORD_BITS:1] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: compares each presented word once, then checks it stays frozen
  // until it is taken after take_delay cycles.
  logic               seen = 1'b0;
  logic               took = 1'b0;
  int                 hold = 0;
  logic [WORD_BITS:1] held_word;
  exp_t               e;

  always @(negedge clk) begin
    if (took) begin
      bus.word_taken = 1'b0;
      took = 1'b0;
    end
    if (rst) begin
      seen = 1'b0;
    end else if (bus.word_valid) begin
      if (!seen) begin
        seen = 1'b1;
        hold = 0;
        held_word = bus.word;
        if (sb_q.size() == 0) begin
          check("spurious_word_valid", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("word", bus.word, e.word);
          check("word_len", WORD_BITS'(bus.word_len), WORD_BITS'(e.len));
          check("word_truncated", WORD_BITS'(bus.word_truncated), WORD_BITS'(e.trunc));
        end
      end else begin
        check("stall_word_stable", bus.word, held_word);
        check("stall_byte_ready", WORD_BITS'(bus.byte_ready), 0);
      end
      if (hold >= take_delay) begin
        bus.word_taken = 1'b1;
        took = 1'b1;
        seen = 1'b0;
      end
      hold++;
    end
  end

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send(input logic [7:0] b, input logic last);
    int n;
    n = 0;
    bus.byte_valid = 1'b1;
    bus.byte_in    = b;
    bus.byte_last  = last;
    while (!bus.byte_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("byte_ready_timeout", 0, 1);
    @(negedge clk);
    bus.byte_valid = 1'b0;
    bus.byte_last  = 1'b0;
  endtask

  task automatic push_exp(input logic [WORD_BITS:1] w, input logic [LEN_BITS-1:0] l,
                          input logic t);
    exp_t x;
    x.word = w; x.len = l; x.trunc = t;
    sb_q.push_back(x);
  endtask

  function automatic logic [WORD_BITS:1] fill(input logic [7:0] c, input int n);
    logic [WORD_BITS:1] w;
    w = '0;
    for (int k = 0; k < n; k++) w[8*k+1 +: 8] = c;
    return w;
  endfunction

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || bus.word_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check(name, WORD_BITS'(sb_q.size()), 0);
  endtask

  vec_t vecs[$];

  function automatic vec_t mk(input logic [7:0] b, input logic last, input logic emit,
                              input logic [WORD_BITS:1] w, input logic [LEN_BITS-1:0] l,
                              input logic t);
    vec_t v;
    v.b = b; v.last = last; v.emit = emit; v.exp_word = w; v.exp_len = l; v.exp_trunc = t;
    return v;
  endfunction

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_in    = 8'h00;
    bus.byte_last  = 1'b0;
    bus.word_taken = 1'b0;

    vecs.push_back(mk(8'h48, 0, 0, '0, 0, 0));
    vecs.push_back(mk(8'h69, 0, 0, '0, 0, 0));
    vecs.push_back(mk(8'h2C, 0, 1, WORD_BITS'(16'h6968), 2, 0));
    vecs.push_back(mk(8'h20, 0, 0, '0, 0, 0));
    vecs.push_back(mk(8'h63, 0, 0, '0, 0, 0));
    vecs.push_back(mk(8'h61, 0, 0, '0, 0, 0));
    vecs.push_back(mk(8'h74, 1, 1, WORD_BITS'(24'h746163), 3, 0));
    vecs.push_back(mk(8'h5A, 0, 0, '0, 0, 0));
    vecs.push_back(mk(8'h40, 0, 1, WORD_BITS'(8'h7A), 1, 0));
    vecs.push_back(mk(8'h5B, 0, 0, '0, 0, 0));
    vecs.push_back(mk(8'h7A, 0, 0, '0, 0, 0));
    vecs.push_back(mk(8'h7B, 0, 1, WORD_BITS'(8'h7A), 1, 0));

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_byte_ready", WORD_BITS'(bus.byte_ready), 1);
    check("rst_word_valid", WORD_BITS'(bus.word_valid), 0);
    check("rst_word", bus.word, '0);
    check("rst_word_len", WORD_BITS'(bus.word_len), 0);
    check("rst_word_truncated", WORD_BITS'(bus.word_truncated), 0);

    // word_taken with nothing pending
    bus.word_taken = 1'b1;
    @(negedge clk);
    bus.word_taken = 1'b0;
    @(negedge clk);
    check("idle_take_valid", WORD_BITS'(bus.word_valid), 0);
    check("idle_take_ready", WORD_BITS'(bus.byte_ready), 1);

    foreach (vecs[i]) begin
      if (vecs[i].emit) push_exp(vecs[i].exp_word, vecs[i].exp_len, vecs[i].exp_trunc);
      send(vecs[i].b, vecs[i].last);
      if (vecs[i].emit) begin
        check("emit_latency_valid", WORD_BITS'(bus.word_valid), 1);
        check("emit_latency_ready", WORD_BITS'(bus.byte_ready), 0);
      end
    end
    drain("drain_table");

    // 40 letters: truncation, then a fresh token must not inherit it
    for (int i = 0; i < 40; i++) send(8'h61, 0);
    push_exp(fill(8'h61, 32), 32, 1);
    send(8'h20, 0);
    push_exp(WORD_BITS'(8'h62), 1, 0);
    send(8'h62, 0);
    send(8'h20, 0);
    drain("drain_trunc");

    // exactly 32 letters ending on byte_last is full but not truncated
    for (int i = 0; i < 31; i++) send(8'h43, 0);
    push_exp(fill(8'h63, 32), 32, 0);
    send(8'h43, 1);
    drain("drain_full");

    // stall: word held 10 cycles while the next token's bytes wait
    take_delay = 10;
    send(8'h78, 0);
    send(8'h79, 0);
    push_exp(WORD_BITS'(16'h7978), 2, 0);
    send(8'h20, 0);
    push_exp(WORD_BITS'(8'h71), 1, 0);
    send(8'h51, 1);
    drain("drain_stall");
    take_delay = 0;

    // reset mid-token discards the partial "ab"
    send(8'h61, 0);
    send(8'h62, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_word", bus.word, '0);
    check("midrst_word_len", WORD_BITS'(bus.word_len), 0);
    check("midrst_byte_ready", WORD_BITS'(bus.byte_ready), 1);
    push_exp(WORD_BITS'(8'h63), 1, 0);
    send(8'h63, 0);
    send(8'h20, 0);
    drain("drain_reset");

    repeat (3) @(negedge clk);
    check("end_word_valid", WORD_BITS'(bus.word_valid), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
